// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round-constant seed, FSM state type and GF(2^8) xtime.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [0:0] {IDLE, EMIT} state_e;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Round-key stream: valid/ready handshake carrying the round key and its index.
interface aes_key_expand_if;
  import aes_pkg::*;

  logic                 rk_valid;
  logic                 rk_ready;
  logic [AES_KEY_W-1:0] rk_data;
  logic [3:0]           rk_idx;

  modport master (output rk_valid, output rk_data, output rk_idx, input rk_ready);
  modport slave  (input rk_valid, input rk_data, input rk_idx, output rk_ready);

endinterface

// File: rtl/sbox.sv
// AES forward S-box as a combinational table lookup.
module sbox (
  input  logic [7:0] data,
  output logic [7:0] result
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry d starts at bit 8*(255-d)+7.
  assign result = SBOX_TBL[{~data, 3'b111} -: 8];

endmodule

// File: rtl/sub_word.sv
// SubWord: byte-wise S-box substitution of a 32-bit word.
module sub_word (
  input  logic [31:0] data,
  output logic [31:0] result
);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    sbox u_sbox (
      .data   (data[8*i +: 8]),
      .result (result[8*i +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule streaming round keys 0..NR over a valid/ready interface.
// Define AES_KEYEXP_ZEROIZE_EN to clear the key register after the final key or an abort.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 abort,
  aes_key_expand_if.master     rk,
  output logic                 busy,
  output logic                 done
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_expand: only NR = 10 is supported");
  end

`ifdef AES_KEYEXP_ZEROIZE_EN
  localparam logic ZEROIZE = 1'b1;
`else
  localparam logic ZEROIZE = 1'b0;
`endif

  state_e               state_q, state_d;
  logic [AES_KEY_W-1:0] key_q, key_d;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           rcon_q, rcon_d;
  logic                 done_q, done_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t;
  logic [31:0] n0, n1, n2, n3;
  logic        hs, last;

  assign {w0, w1, w2, w3} = key_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  sub_word u_sub_word (
    .data   (rot_w3),
    .result (sub_w3)
  );

  assign t  = sub_w3 ^ {rcon_q, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign hs   = (state_q == EMIT) && rk.rk_ready;
  assign last = (idx_q == 4'(NR));

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Abort outranks start even when nothing is running.
        if (start && !abort) begin
          key_d   = key_in;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (abort) begin
          state_d = IDLE;
          if (ZEROIZE) key_d = '0;
        end else if (hs) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (ZEROIZE) key_d = '0;
          end else begin
            key_d  = {n0, n1, n2, n3};
            idx_d  = idx_q + 4'd1;
            rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= RCON_INIT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  assign rk.rk_valid = (state_q == EMIT);
  assign rk.rk_data  = key_q;
  assign rk.rk_idx   = idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand; expected keys come from an independent S-box/key-schedule model.
module tb_aes_key_expand;
  import aes_pkg::*;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } exp_t;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;
  localparam logic [127:0] KEY_ALT  = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, done;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [7:0] sbox_m [256];

  aes_key_expand_if rk_if ();

  aes_key_expand dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key_in (key_in),
    .abort  (abort),
    .rk     (rk_if),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic void push_expected(input logic [127:0] k);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    exp_t        e;
    {w0, w1, w2, w3} = k;
    rc = 8'h01;
    e.idx = 4'd0; e.data = k;
    exp_q.push_back(e);
    for (int r = 1; r <= 10; r++) begin
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      e.idx = 4'(r); e.data = {w0, w1, w2, w3};
      exp_q.push_back(e);
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end
  endfunction

  function automatic exp_t pop_expected();
    exp_t e;
    e = '1;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    return e;
  endfunction

  // Pulse start for one cycle; returns on the falling edge after the capturing edge.
  task automatic start_key(input logic [127:0] k);
    @(negedge clk);
    start = 1'b1; key_in = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_data, busy, done} !== '0) begin
      bad++; $display("FAIL reset_hold got=%b/%h/%h/%b/%b exp=all zero", rk_if.rk_valid,
                      rk_if.rk_idx, rk_if.rk_data, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rk_if.rk_valid, busy, done} !== 3'b000) begin
      bad++; $display("FAIL reset_release got=%b/%b/%b exp=0/0/0", rk_if.rk_valid, busy, done);
    end
  endtask

  task automatic test_fips();
    exp_t e;
    int   n = 0;
    int   cyc = 0;
    exp_q.delete();
    push_expected(KEY_A1);
    rk_if.rk_ready = 1'b1;
    start_key(KEY_A1);
    total++;
    if ({rk_if.rk_valid, rk_if.rk_idx} !== 5'b1_0000) begin
      bad++; $display("FAIL fips_latency got=%b/%0d exp=1/0", rk_if.rk_valid, rk_if.rk_idx);
    end
    while (n < 11 && cyc < 50) begin
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        e = pop_expected();
        total++;
        if ({rk_if.rk_idx, rk_if.rk_data} !== {e.idx, e.data}) begin
          bad++; $display("FAIL fips_key got=%0d/%h exp=%0d/%h", rk_if.rk_idx, rk_if.rk_data,
                          e.idx, e.data);
        end
        if (e.idx == 4'd1) begin
          total++;
          if (rk_if.rk_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            bad++; $display("FAIL fips_idx1 got=%h exp=a0fafe1788542cb123a339392a6c7605",
                            rk_if.rk_data);
          end
        end
        if (e.idx == 4'd10) begin
          total++;
          if (rk_if.rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            bad++; $display("FAIL fips_idx10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6",
                            rk_if.rk_data);
          end
        end
        n++;
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (n != 11 || cyc != 11) begin
      bad++; $display("FAIL fips_count got=%0d keys in %0d cycles exp=11 in 11", n, cyc);
    end
    total++;
    if ({done, busy, rk_if.rk_valid} !== 3'b100) begin
      bad++; $display("FAIL fips_done got=%b/%b/%b exp=1/0/0", done, busy, rk_if.rk_valid);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL fips_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_zero_key_back_to_back();
    exp_t e;
    int   n = 0;
    int   cyc = 0;
    exp_q.delete();
    push_expected(KEY_ZERO);
    rk_if.rk_ready = 1'b1;
    start_key(KEY_ZERO);
    while (n < 11 && cyc < 50) begin
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        e = pop_expected();
        total++;
        if ({rk_if.rk_idx, rk_if.rk_data} !== {e.idx, e.data}) begin
          bad++; $display("FAIL zero_key got=%0d/%h exp=%0d/%h", rk_if.rk_idx, rk_if.rk_data,
                          e.idx, e.data);
        end
        if (e.idx == 4'd1 && rk_if.rk_data !== 128'h62636363626363636263636362636363) begin
          bad++; $display("FAIL zero_idx1 got=%h exp=62636363626363636263636362636363",
                          rk_if.rk_data);
        end
        if (e.idx == 4'd10 && rk_if.rk_data !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
          bad++; $display("FAIL zero_idx10 got=%h exp=b4ef5bcb3e92e21123e951cf6f8f188e",
                          rk_if.rk_data);
        end
        if (e.idx == 4'd1 || e.idx == 4'd10) total++;
        n++;
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (n != 11 || done !== 1'b1) begin
      bad++; $display("FAIL zero_done got=%0d keys done=%b exp=11 done=1", n, done);
    end
    // New start while done is still high.
    start = 1'b1; key_in = KEY_A1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_data} !== {1'b1, 4'd0, KEY_A1}) begin
      bad++; $display("FAIL b2b_start got=%b/%0d/%h exp=1/0/%h", rk_if.rk_valid, rk_if.rk_idx,
                      rk_if.rk_data, KEY_A1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t         e;
    int           n = 0;
    int           cyc = 0;
    logic         held = 1'b0;
    logic [131:0] held_v = '0;
    exp_q.delete();
    push_expected(KEY_A1);
    rk_if.rk_ready = 1'b0;
    start_key(KEY_A1);
    while (n < 11 && cyc < 400) begin
      if (held) begin
        total++;
        if ({rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_data} !== {1'b1, held_v}) begin
          bad++; $display("FAIL bp_stall got=%b/%0d/%h exp=1/%0d/%h", rk_if.rk_valid,
                          rk_if.rk_idx, rk_if.rk_data, held_v[131:128], held_v[127:0]);
        end
      end
      rk_if.rk_ready = ($urandom_range(0, 99) < 40);
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        e = pop_expected();
        total++;
        if ({rk_if.rk_idx, rk_if.rk_data} !== {e.idx, e.data}) begin
          bad++; $display("FAIL bp_key got=%0d/%h exp=%0d/%h", rk_if.rk_idx, rk_if.rk_data,
                          e.idx, e.data);
        end
        n++;
      end
      held   = rk_if.rk_valid && !rk_if.rk_ready;
      held_v = {rk_if.rk_idx, rk_if.rk_data};
      @(negedge clk); cyc++;
    end
    total++;
    if (n != 11 || done !== 1'b1) begin
      bad++; $display("FAIL bp_done got=%0d keys done=%b exp=11 done=1", n, done);
    end
    rk_if.rk_ready = 1'b1;
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   n = 0;
    int   cyc = 0;
    exp_q.delete();
    push_expected(KEY_A1);
    rk_if.rk_ready = 1'b1;
    start_key(KEY_A1);
    while (n < 11 && cyc < 50) begin
      start  = (rk_if.rk_idx == 4'd3);
      key_in = KEY_ALT;
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        e = pop_expected();
        total++;
        if ({rk_if.rk_idx, rk_if.rk_data} !== {e.idx, e.data}) begin
          bad++; $display("FAIL busy_start_key got=%0d/%h exp=%0d/%h", rk_if.rk_idx,
                          rk_if.rk_data, e.idx, e.data);
        end
        n++;
      end
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    total++;
    if (n != 11 || done !== 1'b1) begin
      bad++; $display("FAIL busy_start_done got=%0d keys done=%b exp=11 done=1", n, done);
    end
  endtask

  task automatic test_abort();
    exp_t         e;
    int           cyc = 0;
    logic         aborted = 1'b0;
    logic [127:0] exp_data = '0;
    exp_q.delete();
    push_expected(KEY_A1);
    rk_if.rk_ready = 1'b1;
    start_key(KEY_A1);
    while (!aborted && cyc < 50) begin
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        e = pop_expected();
        total++;
        if ({rk_if.rk_idx, rk_if.rk_data} !== {e.idx, e.data}) begin
          bad++; $display("FAIL abort_key got=%0d/%h exp=%0d/%h", rk_if.rk_idx, rk_if.rk_data,
                          e.idx, e.data);
        end
        // Abort coincides with a handshake here; it must not count as consumed.
        if (e.idx == 4'd5) begin
          abort = 1'b1; aborted = 1'b1; exp_data = e.data;
        end
      end
      @(negedge clk); cyc++;
    end
    abort = 1'b0;
`ifdef AES_KEYEXP_ZEROIZE_EN
    exp_data = '0;
`endif
    total++;
    if ({aborted, rk_if.rk_valid, busy, done} !== 4'b1000) begin
      bad++; $display("FAIL abort_idle got=%b/%b/%b/%b exp=1/0/0/0", aborted, rk_if.rk_valid,
                      busy, done);
    end
    total++;
    if (rk_if.rk_data !== exp_data) begin
      bad++; $display("FAIL abort_data got=%h exp=%h", rk_if.rk_data, exp_data);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL abort_no_done got=%b exp=0", done);
    end
    start = 1'b1; abort = 1'b1; key_in = KEY_ALT;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    total++;
    if ({busy, rk_if.rk_valid} !== 2'b00) begin
      bad++; $display("FAIL start_abort_idle got=%b/%b exp=0/0", busy, rk_if.rk_valid);
    end
    start_key(KEY_ALT);
    total++;
    if ({rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_data} !== {1'b1, 4'd0, KEY_ALT}) begin
      bad++; $display("FAIL abort_restart got=%b/%0d/%h exp=1/0/%h", rk_if.rk_valid,
                      rk_if.rk_idx, rk_if.rk_data, KEY_ALT);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   n = 0;
    int   cyc = 0;
    exp_q.delete();
    rk_if.rk_ready = 1'b1;
    start_key(KEY_A1);
    while (rk_if.rk_idx != 4'd7 && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({rk_if.rk_valid, rk_if.rk_idx, rk_if.rk_data, busy, done} !== '0) begin
      bad++; $display("FAIL async_reset got=%b/%0d/%h/%b/%b exp=all zero", rk_if.rk_valid,
                      rk_if.rk_idx, rk_if.rk_data, busy, done);
    end
    @(negedge clk); rst = 1'b0;
    push_expected(KEY_ZERO);
    start_key(KEY_ZERO);
    cyc = 0;
    while (n < 11 && cyc < 50) begin
      if (rk_if.rk_valid && rk_if.rk_ready) begin
        e = pop_expected();
        total++;
        if ({rk_if.rk_idx, rk_if.rk_data} !== {e.idx, e.data}) begin
          bad++; $display("FAIL post_reset_key got=%0d/%h exp=%0d/%h", rk_if.rk_idx,
                          rk_if.rk_data, e.idx, e.data);
        end
        n++;
      end
      @(negedge clk); cyc++;
    end
    total++;
    if (n != 11 || done !== 1'b1) begin
      bad++; $display("FAIL post_reset_done got=%0d keys done=%b exp=11 done=1", n, done);
    end
  endtask

  initial begin
    rk_if.rk_ready = 1'b0;
    build_sbox();
    test_reset();
    test_fips();
    test_zero_key_back_to_back();
    test_backpressure();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
